// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection, flush bubbles and downstream hold.
// Optional statistics counters are enabled by defining ID_EX_STATS_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_Rs,
  input  logic [REG_AW-1:0] IF_ID_Rt,
  input  logic [REG_AW-1:0] IF_ID_Rd,
  input  logic [DATA_W-1:0] IF_ID_ReadData1,
  input  logic [DATA_W-1:0] IF_ID_ReadData2,
  input  logic [DATA_W-1:0] IF_ID_Imm,
  input  logic [7:0]        IF_ID_Ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic [REG_AW-1:0] ID_Ex_Rs,
  output logic [REG_AW-1:0] ID_Ex_Rt,
  output logic [REG_AW-1:0] ID_Ex_Rd,
  output logic [DATA_W-1:0] ID_Ex_Data1,
  output logic [DATA_W-1:0] ID_Ex_Data2,
  output logic [DATA_W-1:0] ID_Ex_Imm,
  output logic [7:0]        ID_Ex_Ctrl,
  output logic              ID_Ex_Valid,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_d1, r_d2, r_imm;
  logic [7:0]        r_ctrl;
  logic              r_valid;
  logic              w_lu;
  logic              w_bubble;
  logic              w_advance;
  // Load in EX whose destination feeds the instruction now in ID; Ctrl[6] is MemRead
  always_comb begin
    w_lu      = r_valid & r_ctrl[6] & (r_rt != '0) & ((r_rt == IF_ID_Rs) | (r_rt == IF_ID_Rt));
    w_bubble  = flush | w_lu;
    w_advance = ~rst_n | ~(w_lu | hold);
  end
  assign PCWrite    = w_advance;
  assign IF_IDWrite = w_advance;
  // Pipeline register: hold freezes everything, bubbles still load operands but zero control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (!hold) begin
      r_rs    <= IF_ID_Rs;
      r_rt    <= IF_ID_Rt;
      r_rd    <= IF_ID_Rd;
      r_d1    <= IF_ID_ReadData1;
      r_d2    <= IF_ID_ReadData2;
      r_imm   <= IF_ID_Imm;
      r_ctrl  <= w_bubble ? 8'h00 : IF_ID_Ctrl;
      r_valid <= ~w_bubble;
    end
  end
  assign ID_Ex_Rs    = r_rs;
  assign ID_Ex_Rt    = r_rt;
  assign ID_Ex_Rd    = r_rd;
  assign ID_Ex_Data1 = r_d1;
  assign ID_Ex_Data2 = r_d2;
  assign ID_Ex_Imm   = r_imm;
  assign ID_Ex_Ctrl  = r_ctrl;
  assign ID_Ex_Valid = r_valid;
`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  // Saturating bubble counters; flush wins attribution when it coincides with a load-use hazard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (~&r_flush_cnt) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (w_lu && ~&r_stall_cnt) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: table-driven directed bench for id_ex_stage_reg plus reset-versus-hazard sequence.
module tb_id_ex_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [31:0] d1 = '0, d2 = '0, imm = '0;
  logic [7:0]  ctrl = '0;
  logic        flush = 1'b0, hold = 1'b0;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [31:0] o_d1, o_d2, o_imm;
  logic [7:0]  o_ctrl;
  logic        o_valid, o_pcw, o_ifw;
  logic [15:0] o_sc, o_fc;
  int n_chk = 0;
  int n_fail = 0;
`ifdef ID_EX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_Rd(rd),
    .IF_ID_ReadData1(d1), .IF_ID_ReadData2(d2), .IF_ID_Imm(imm), .IF_ID_Ctrl(ctrl),
    .flush(flush), .hold(hold),
    .ID_Ex_Rs(o_rs), .ID_Ex_Rt(o_rt), .ID_Ex_Rd(o_rd),
    .ID_Ex_Data1(o_d1), .ID_Ex_Data2(o_d2), .ID_Ex_Imm(o_imm), .ID_Ex_Ctrl(o_ctrl),
    .ID_Ex_Valid(o_valid), .PCWrite(o_pcw), .IF_IDWrite(o_ifw),
    .stall_cnt(o_sc), .flush_cnt(o_fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, flush, hold;
    logic [4:0]  rs, rt;
    logic [7:0]  ctrl;
    logic [31:0] d1;
    logic        pcw;
    logic [4:0]  e_rs, e_rt;
    logic [7:0]  e_ctrl;
    logic [31:0] e_d1;
    logic        e_valid;
    int          e_sc, e_fc;
  } vec_t;

  vec_t v[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic h, input logic [4:0] s,
                       input logic [4:0] t, input logic [7:0] c, input logic [31:0] a);
    @(negedge clk);
    rst_n = r; flush = f; hold = h; rs = s; rt = t; rd = t + 5'd1;
    ctrl = c; d1 = a; d2 = a + 32'd1; imm = a + 32'd2;
    #1;
  endtask

  initial begin
    v[0]  = '{1'b0,1'b0,1'b0, 5'd7,5'd8,  8'hFF,32'hAA, 1'b1, 5'd0,5'd0,  8'h00,32'h00,1'b0, 0,0};
    v[1]  = '{1'b0,1'b0,1'b0, 5'd1,5'd2,  8'h40,32'hBB, 1'b1, 5'd0,5'd0,  8'h00,32'h00,1'b0, 0,0};
    v[2]  = '{1'b1,1'b0,1'b0, 5'd3,5'd4,  8'h83,32'h11, 1'b1, 5'd3,5'd4,  8'h83,32'h11,1'b1, 0,0};
    v[3]  = '{1'b1,1'b0,1'b0, 5'd1,5'd8,  8'hC0,32'h44, 1'b1, 5'd1,5'd8,  8'hC0,32'h44,1'b1, 0,0};
    v[4]  = '{1'b1,1'b0,1'b0, 5'd8,5'd9,  8'h82,32'h55, 1'b0, 5'd8,5'd9,  8'h00,32'h55,1'b0, 1,0};
    v[5]  = '{1'b1,1'b0,1'b0, 5'd8,5'd9,  8'h82,32'h55, 1'b1, 5'd8,5'd9,  8'h82,32'h55,1'b1, 1,0};
    v[6]  = '{1'b1,1'b0,1'b0, 5'd2,5'd0,  8'hC0,32'h66, 1'b1, 5'd2,5'd0,  8'hC0,32'h66,1'b1, 1,0};
    v[7]  = '{1'b1,1'b0,1'b0, 5'd0,5'd3,  8'h82,32'h77, 1'b1, 5'd0,5'd3,  8'h82,32'h77,1'b1, 1,0};
    v[8]  = '{1'b1,1'b0,1'b0, 5'd1,5'd6,  8'hC0,32'h88, 1'b1, 5'd1,5'd6,  8'hC0,32'h88,1'b1, 1,0};
    v[9]  = '{1'b1,1'b0,1'b0, 5'd6,5'd6,  8'hC0,32'h99, 1'b0, 5'd6,5'd6,  8'h00,32'h99,1'b0, 2,0};
    v[10] = '{1'b1,1'b0,1'b0, 5'd6,5'd6,  8'hC0,32'h99, 1'b1, 5'd6,5'd6,  8'hC0,32'h99,1'b1, 2,0};
    v[11] = '{1'b1,1'b0,1'b0, 5'd2,5'd6,  8'h82,32'hAB, 1'b0, 5'd2,5'd6,  8'h00,32'hAB,1'b0, 3,0};
    v[12] = '{1'b1,1'b0,1'b0, 5'd2,5'd6,  8'h82,32'hAB, 1'b1, 5'd2,5'd6,  8'h82,32'hAB,1'b1, 3,0};
    v[13] = '{1'b1,1'b0,1'b0, 5'd1,5'd5,  8'hC0,32'hCD, 1'b1, 5'd1,5'd5,  8'hC0,32'hCD,1'b1, 3,0};
    v[14] = '{1'b1,1'b1,1'b0, 5'd5,5'd1,  8'h82,32'hEF, 1'b0, 5'd5,5'd1,  8'h00,32'hEF,1'b0, 3,1};
    v[15] = '{1'b1,1'b0,1'b0, 5'd3,5'd4,  8'h83,32'h21, 1'b1, 5'd3,5'd4,  8'h83,32'h21,1'b1, 3,1};
    v[16] = '{1'b1,1'b1,1'b1, 5'd4,5'd4,  8'hC0,32'h31, 1'b0, 5'd3,5'd4,  8'h83,32'h21,1'b1, 3,1};
    v[17] = '{1'b1,1'b1,1'b1, 5'd5,5'd4,  8'hC0,32'h32, 1'b0, 5'd3,5'd4,  8'h83,32'h21,1'b1, 3,1};
    v[18] = '{1'b1,1'b1,1'b1, 5'd6,5'd4,  8'hC0,32'h33, 1'b0, 5'd3,5'd4,  8'h83,32'h21,1'b1, 3,1};
    v[19] = '{1'b1,1'b1,1'b0, 5'd9,5'd10, 8'h82,32'h41, 1'b1, 5'd9,5'd10, 8'h00,32'h41,1'b0, 3,2};
    v[20] = '{1'b1,1'b0,1'b0, 5'd0,5'd7,  8'hC0,32'h51, 1'b1, 5'd0,5'd7,  8'hC0,32'h51,1'b1, 3,2};
    v[21] = '{1'b1,1'b0,1'b1, 5'd7,5'd1,  8'h82,32'h61, 1'b0, 5'd0,5'd7,  8'hC0,32'h51,1'b1, 3,2};
    v[22] = '{1'b1,1'b0,1'b0, 5'd7,5'd1,  8'h82,32'h61, 1'b0, 5'd7,5'd1,  8'h00,32'h61,1'b0, 4,2};
    v[23] = '{1'b0,1'b0,1'b0, 5'd7,5'd1,  8'hC0,32'h71, 1'b1, 5'd0,5'd0,  8'h00,32'h00,1'b0, 0,0};
    for (int i = 0; i < 24; i++) begin
      drive(v[i].rst_n, v[i].flush, v[i].hold, v[i].rs, v[i].rt, v[i].ctrl, v[i].d1);
      chk($sformatf("v%0d PCWrite", i), {31'd0, o_pcw}, {31'd0, v[i].pcw});
      chk($sformatf("v%0d IF_IDWrite", i), {31'd0, o_ifw}, {31'd0, v[i].pcw});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d Rs", i), {27'd0, o_rs}, {27'd0, v[i].e_rs});
      chk($sformatf("v%0d Rt", i), {27'd0, o_rt}, {27'd0, v[i].e_rt});
      chk($sformatf("v%0d Rd", i), {27'd0, o_rd}, v[i].e_d1 == 0 ? 32'd0 : {27'd0, v[i].e_rt + 5'd1});
      chk($sformatf("v%0d Data1", i), o_d1, v[i].e_d1);
      chk($sformatf("v%0d Data2", i), o_d2, v[i].e_d1 == 0 ? 32'd0 : v[i].e_d1 + 32'd1);
      chk($sformatf("v%0d Imm", i), o_imm, v[i].e_d1 == 0 ? 32'd0 : v[i].e_d1 + 32'd2);
      chk($sformatf("v%0d Ctrl", i), {24'd0, o_ctrl}, {24'd0, v[i].e_ctrl});
      chk($sformatf("v%0d Valid", i), {31'd0, o_valid}, {31'd0, v[i].e_valid});
      chk($sformatf("v%0d stall_cnt", i), {16'd0, o_sc}, STATS ? v[i].e_sc : 32'd0);
      chk($sformatf("v%0d flush_cnt", i), {16'd0, o_fc}, STATS ? v[i].e_fc : 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 5'd2, 5'd8, 8'hC0, 32'h90);
    @(posedge clk);
    #1;
    chk("seq lw loaded Valid", {31'd0, o_valid}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 5'd3, 8'h82, 32'h91);
    chk("seq reset PCWrite", {31'd0, o_pcw}, 32'd1);
    chk("seq reset IF_IDWrite", {31'd0, o_ifw}, 32'd1);
    @(posedge clk);
    #1;
    chk("seq reset Valid", {31'd0, o_valid}, 32'd0);
    chk("seq reset Ctrl", {24'd0, o_ctrl}, 32'd0);
    chk("seq reset Data1", o_d1, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd8, 5'd3, 8'h82, 32'h92);
    chk("seq post-reset PCWrite", {31'd0, o_pcw}, 32'd1);
    @(posedge clk);
    #1;
    chk("seq post-reset Valid", {31'd0, o_valid}, 32'd1);
    chk("seq post-reset stall_cnt", {16'd0, o_sc}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
